memory_game_grid: RTL and testbench

Parametrised successor of the team's memory-game controller.
- Generates a GRID_N x GRID_N target bit-grid from a seed and an increment, then counts the set cells.
- Runs the play phase: cursor movement, select, lives and score.
- Adds multi-level play, where each cleared level regenerates the grid from the advancing seed, plus a found-cell mask and status outputs for the top-level display logic.

---
 rtl/memory_game_grid.sv | 208 ++++++++++++++++++++
 tb/tb_memory_game_grid.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/memory_game_grid.sv
// Memory-game controller: seeded GRID_N x GRID_N target generation, cell count, play, multi-level.
// Build option: define CURSOR_WRAP_EN to make cursor movement wrap at the grid edges.
module memory_game_grid #(
  parameter int GRID_N    = 4,
  parameter int MAX_LIVES = 3,
  parameter int SCORE_W   = 8,
  localparam int CUR_W    = $clog2(GRID_N),
  localparam int LIVES_W  = $clog2(MAX_LIVES + 1),
  localparam int CELLS    = GRID_N * GRID_N,
  localparam int REM_W    = $clog2(CELLS + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic [GRID_N-1:0]  SS_in,
  input  logic [GRID_N-1:0]  INC_in,
  input  logic               Right,
  input  logic               Left,
  input  logic               Up,
  input  logic               Down,
  input  logic               Select,
  output logic [LIVES_W-1:0] Lives,
  output logic [SCORE_W-1:0] Score,
  output logic [CUR_W-1:0]   CurX,
  output logic [CUR_W-1:0]   CurY,
  output logic [CELLS-1:0]   Target,
  output logic [CELLS-1:0]   Found,
  output logic [REM_W-1:0]   Remaining,
  output logic               Qi,
  output logic               Qg,
  output logic               Qc,
  output logic               Qp,
  output logic               Qv,
  output logic               Ql
);

  localparam int CELL_W = $clog2(CELLS);

  localparam logic [CUR_W-1:0]   CUR_ONE    = CUR_W'(1);
  localparam logic [CUR_W-1:0]   CUR_LAST   = CUR_W'(GRID_N - 1);
  localparam logic [CELL_W-1:0]  CELL_ONE   = CELL_W'(1);
  localparam logic [CELL_W-1:0]  CELL_LAST  = CELL_W'(CELLS - 1);
  localparam logic [CELL_W-1:0]  CELL_SIDE  = CELL_W'(GRID_N);
  localparam logic [REM_W-1:0]   REM_ONE    = REM_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [GRID_N-1:0]  SEED_ONE   = GRID_N'(1);

  // One-hot encoding so the Q* status lines are plain state-register bits.
  typedef enum logic [5:0] {
    S_INITIAL  = 6'b000001,
    S_GENERATE = 6'b000010,
    S_COUNT    = 6'b000100,
    S_PLAY     = 6'b001000,
    S_LEVEL    = 6'b010000,
    S_LOSE     = 6'b100000
  } state_t;

  state_t            state_reg;
  logic [GRID_N-1:0] seed_reg;
  logic [GRID_N-1:0] inc_reg;
  logic [CUR_W-1:0]  row_reg;
  logic [CELL_W-1:0] scan_reg;

  logic [CELL_W-1:0] cell_idx;
  logic              cur_target;
  logic              cur_found;
  logic [REM_W-1:0]  count_total;
  logic [CUR_W-1:0]  x_inc, x_dec, y_inc, y_dec;

  assign cell_idx    = CELL_W'(CurY) * CELL_SIDE + CELL_W'(CurX);
  assign cur_target  = Target[cell_idx];
  assign cur_found   = Found[cell_idx];
  assign count_total = Remaining + REM_W'(Target[scan_reg]);

  always_comb begin
    x_inc = CurX;
    x_dec = CurX;
    y_inc = CurY;
    y_dec = CurY;
`ifdef CURSOR_WRAP_EN
    x_inc = (CurX == CUR_LAST) ? '0 : CurX + CUR_ONE;
    x_dec = (CurX == '0) ? CUR_LAST : CurX - CUR_ONE;
    y_inc = (CurY == CUR_LAST) ? '0 : CurY + CUR_ONE;
    y_dec = (CurY == '0) ? CUR_LAST : CurY - CUR_ONE;
`else
    if (CurX != CUR_LAST) x_inc = CurX + CUR_ONE;
    if (CurX != '0)       x_dec = CurX - CUR_ONE;
    if (CurY != CUR_LAST) y_inc = CurY + CUR_ONE;
    if (CurY != '0)       y_dec = CurY - CUR_ONE;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_INITIAL;
      seed_reg  <= '0;
      inc_reg   <= '0;
      row_reg   <= '0;
      scan_reg  <= '0;
      Lives     <= '0;
      Score     <= '0;
      CurX      <= '0;
      CurY      <= '0;
      Target    <= '0;
      Found     <= '0;
      Remaining <= '0;
    end else begin
      unique case (state_reg)
        S_INITIAL: begin
          if (Start) begin
            seed_reg  <= SS_in;
            inc_reg   <= INC_in;
            Lives     <= LIVES_INIT;
            Score     <= '0;
            CurX      <= '0;
            CurY      <= '0;
            row_reg   <= '0;
            state_reg <= S_GENERATE;
          end
        end

        S_GENERATE: begin
          for (int r = 0; r < GRID_N; r++) begin
            if (row_reg == CUR_W'(r)) begin
              Target[r*GRID_N +: GRID_N] <= seed_reg;
              Found[r*GRID_N +: GRID_N]  <= '0;
            end
          end
          seed_reg <= seed_reg + inc_reg;
          if (row_reg == CUR_LAST) begin
            Remaining <= '0;
            scan_reg  <= '0;
            state_reg <= S_COUNT;
          end else begin
            row_reg <= row_reg + CUR_ONE;
          end
        end

        S_COUNT: begin
          Remaining <= count_total;
          scan_reg  <= scan_reg + CELL_ONE;
          if (scan_reg == CELL_LAST) begin
            if (count_total == '0) begin
              // Empty grid: nudge the seed so a zero increment cannot loop forever.
              seed_reg  <= seed_reg + inc_reg + SEED_ONE;
              row_reg   <= '0;
              state_reg <= S_GENERATE;
            end else begin
              CurX      <= '0;
              CurY      <= '0;
              state_reg <= S_PLAY;
            end
          end
        end

        S_PLAY: begin
          if (Right) begin
            CurX <= x_inc;
          end else if (Left) begin
            CurX <= x_dec;
          end else if (Up) begin
            CurY <= y_dec;
          end else if (Down) begin
            CurY <= y_inc;
          end else if (Select) begin
            if (cur_target) begin
              if (!cur_found) begin
                Found[cell_idx] <= 1'b1;
                Remaining       <= Remaining - REM_ONE;
                if (Remaining == REM_ONE) begin
                  if (Score != '1) Score <= Score + SCORE_ONE;
                  state_reg <= S_LEVEL;
                end
              end
            end else begin
              Lives <= Lives - LIVES_ONE;
              if (Lives == LIVES_ONE) state_reg <= S_LOSE;
            end
          end
        end

        S_LEVEL: begin
          if (Ack) begin
            row_reg   <= '0;
            state_reg <= S_GENERATE;
          end
        end

        S_LOSE: begin
          if (Ack) state_reg <= S_INITIAL;
        end

        default: state_reg <= S_INITIAL;
      endcase
    end
  end

  assign Qi = state_reg[0];
  assign Qg = state_reg[1];
  assign Qc = state_reg[2];
  assign Qp = state_reg[3];
  assign Qv = state_reg[4];
  assign Ql = state_reg[5];

endmodule

// File: tb/tb_memory_game_grid.sv
// Directed bench for memory_game_grid (GRID_N=4, MAX_LIVES=3, SCORE_W=8).
module tb_memory_game_grid;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0, Ack = 1'b0;
  logic [3:0]  SS_in = '0, INC_in = '0;
  logic        Right = 1'b0, Left = 1'b0, Up = 1'b0, Down = 1'b0, Select = 1'b0;
  logic [1:0]  Lives;
  logic [7:0]  Score;
  logic [1:0]  CurX, CurY;
  logic [15:0] Target, Found;
  logic [4:0]  Remaining;
  logic        Qi, Qg, Qc, Qp, Qv, Ql;

  int checks = 0;
  int errors = 0;
  int lat;

  memory_game_grid #(.GRID_N(4), .MAX_LIVES(3), .SCORE_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .SS_in(SS_in), .INC_in(INC_in),
    .Right(Right), .Left(Left), .Up(Up), .Down(Down), .Select(Select),
    .Lives(Lives), .Score(Score), .CurX(CurX), .CurY(CurY),
    .Target(Target), .Found(Found), .Remaining(Remaining),
    .Qi(Qi), .Qg(Qg), .Qc(Qc), .Qp(Qp), .Qv(Qv), .Ql(Ql)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One-cycle pulse on any combination of the play inputs.
  task automatic act(input logic r, input logic l, input logic u, input logic d, input logic s);
    Right = r; Left = l; Up = u; Down = d; Select = s;
    tick();
    Right = 1'b0; Left = 1'b0; Up = 1'b0; Down = 1'b0; Select = 1'b0;
  endtask

  // Counts cycles from the edge that took Start/Ack (counted as 1) to PLAY entry.
  task automatic wait_play(output int n);
    n = 1;
    while (!Qp && n < 200) begin
      tick();
      n++;
    end
    chk("play_reached", Qp, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_state", {Qi, Qg, Qc, Qp, Qv, Ql}, 6'b100000);
    chk("rst_outs", {Lives, Score, CurX, CurY, Target, Found, Remaining}, '0);
    Reset = 1'b0;
    tick();

    // Game 1: seed 1, inc 1 -> rows 1,2,3,4
    SS_in = 4'd1; INC_in = 4'd1;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("gen_entered", Qg, 1'b1);
    wait_play(lat);
    chk("latency_g1", lat, 21);
    chk("target_g1", Target, 16'h4321);
    chk("remaining_g1", Remaining, 5);
    chk("lives_g1", Lives, 3);

    act(0, 0, 0, 0, 1);
    chk("sel00_found", Found, 16'h0001);
    chk("sel00_rem", Remaining, 4);
    act(0, 0, 0, 0, 1);
    chk("resel_found", Found, 16'h0001);
    chk("resel_rem_lives", {Remaining, Lives}, {5'd4, 2'd3});
    act(1, 0, 0, 0, 0);
    chk("right_x", CurX, 1);
    act(0, 0, 0, 0, 1);
    chk("miss_lives", Lives, 2);
    chk("miss_found", Found, 16'h0001);
    act(1, 1, 0, 0, 1);
    chk("priority_xy", {CurX, CurY}, {2'd2, 2'd0});
    chk("priority_lives", Lives, 2);
    act(0, 1, 0, 0, 0);
    chk("left_x", CurX, 1);

    act(0, 0, 0, 1, 0); act(0, 0, 0, 0, 1);
    chk("hit11_rem", Remaining, 3);
    act(0, 0, 0, 1, 0); act(0, 0, 0, 0, 1);
    chk("hit12_rem", Remaining, 2);
    act(0, 1, 0, 0, 0); act(0, 0, 0, 0, 1);
    chk("hit02_found", Found, 16'h0321);
    act(0, 0, 0, 1, 0); act(1, 0, 0, 0, 0); act(1, 0, 0, 0, 0);
    chk("pos23", {CurX, CurY}, {2'd2, 2'd3});
    act(0, 0, 0, 0, 1);
    chk("level_found", Found, 16'h4321);
    chk("level_score", Score, 1);
    chk("level_state", {Qv, Qp, Remaining}, {1'b1, 1'b0, 5'd0});
    Start = 1'b1; tick(); Start = 1'b0;
    chk("level_ignores_start", {Qv, Qg}, 2'b10);

    Ack = 1'b1; tick(); Ack = 1'b0;
    wait_play(lat);
    chk("latency_lvl2", lat, 21);
    chk("target_lvl2", Target, 16'h8765);
    chk("remaining_lvl2", Remaining, 8);
    chk("lives_score_lvl2", {Lives, Score}, {2'd2, 8'd1});
    chk("found_lvl2", Found, 16'h0000);
    chk("cursor_lvl2", {CurX, CurY}, 4'h0);

    act(1, 0, 0, 0, 0); act(0, 0, 0, 0, 1);
    chk("lvl2_miss1", Lives, 1);
    act(0, 0, 0, 0, 1);
    chk("lvl2_miss2", Lives, 0);
    chk("lose_state", Ql, 1'b1);
    chk("lose_hold", {Score, Target}, {8'd1, 16'h8765});
    Ack = 1'b1; tick(); Ack = 1'b0;
    chk("lose_ack", Qi, 1'b1);

    // Game 2: all-zero seed/inc forces one regeneration with seed 1
    SS_in = 4'd0; INC_in = 4'd0;
    Start = 1'b1; tick(); Start = 1'b0;
    wait_play(lat);
    chk("latency_g2", lat, 41);
    chk("target_g2", Target, 16'h1111);
    chk("remaining_g2", Remaining, 4);
    chk("lives_score_g2", {Lives, Score}, {2'd3, 8'd0});

    act(0, 1, 0, 0, 0);
`ifdef CURSOR_WRAP_EN
    chk("edge_left", {CurX, CurY}, {2'd3, 2'd0});
`else
    chk("edge_left", {CurX, CurY}, {2'd0, 2'd0});
`endif
    act(0, 0, 1, 0, 0);
`ifdef CURSOR_WRAP_EN
    chk("edge_up", {CurX, CurY}, {2'd3, 2'd3});
`else
    chk("edge_up", {CurX, CurY}, {2'd0, 2'd0});
    act(1, 0, 0, 0, 0);
`endif
    act(0, 0, 0, 0, 1);
    chk("g2_miss1", Lives, 2);
    act(0, 0, 0, 0, 1);
    chk("g2_miss2", Lives, 1);
    act(0, 0, 0, 0, 1);
    chk("g2_miss3", {Lives, Ql}, {2'd0, 1'b1});
    Ack = 1'b1; tick(); Ack = 1'b0;
    chk("g2_ack", Qi, 1'b1);

    // Game 3: asynchronous reset in the middle of PLAY
    SS_in = 4'd1; INC_in = 4'd1;
    Start = 1'b1; tick(); Start = 1'b0;
    wait_play(lat);
    chk("latency_g3", lat, 21);
    act(1, 0, 0, 0, 0);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_rst_state", {Qi, Qg, Qc, Qp, Qv, Ql}, 6'b100000);
    chk("async_rst_outs", {Lives, Score, CurX, CurY, Target, Found, Remaining}, '0);
    tick();
    Reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
